c6ibm_port_deshifter: RTL and testbench
=======================================

Name: c6ibm_port_deshifter

Overview:
Receive-side counterpart of the RAM write-port serializer. Collects NUM_PORTS consecutive DATA_W-bit words from one RAM read port and rebuilds them as parallel ports A/B/C. Raises a one-cycle frame-valid strobe when a frame is complete. Sits between the BRAM32 read port and the IB CNU input registers.

Parameters:
DATA_W, 32, width of each port word.
NUM_PORTS, 3, words per frame; the RTL is written for 3. Any other value is a compile-time error.
CNT_W, 2, slot-counter width; must satisfy 2^CNT_W >= NUM_PORTS.

Ports:
ram_clk  input  1  single clock; all logic on posedge.
rstn  input  1  asynchronous active-low reset.
en  input  1  block enable; low flushes any partial frame.
port_in  input  DATA_W  serialized word from RAM read port.
in_valid  input  1  port_in carries a valid word this cycle.
out_portA  output  DATA_W  frame word 0, the first word received.
out_portB  output  DATA_W  frame word 1.
out_portC  output  DATA_W  frame word 2, the last word received.
out_valid  output  1  one-cycle pulse: out_port* hold a new complete frame.
frame_abort  output  1  one-cycle pulse: a partial frame was discarded.
busy  output  1  a frame is partially collected (slot != 0).

Behaviour:
- Reset (rstn=0, async): slot=0, staging regs=0, out_port*=0, out_valid=0, frame_abort=0, busy=0.
- Accept condition: acc = en & in_valid.
- Slot counter walks 0 -> 1 -> 2 -> 0 and advances only on acc. If in_valid=0 while en=1, the block stalls: slot and staging regs hold.
- Slot 0 accept writes port_in to stageA. Slot 1 accept writes stageB.
- Slot 2 accept loads the output regs on the same edge: out_portA<=stageA, out_portB<=stageB, out_portC<=port_in. out_valid<=1 on that edge; otherwise out_valid<=0.
- Latency: out_valid is high in the cycle after the third word is accepted, so 1 cycle after the last word.
- Back-to-back frames: 3 accepts per frame, no bubble required. out_valid pulses every 3rd accept.
- Outputs hold their value between frames. Only a new complete frame, en low, or reset changes them.
- Bus state machine:
  - IDLE (slot 0). Accept moves to COLLECT.
  - COLLECT (slot 1 or 2). Slot 2 accept moves to IDLE and emits the frame.
  - Any state with en=0 moves to IDLE.
- en=0 behaviour:
  - Next edge: slot<=0, stage regs<=0, out_port*<=0, out_valid<=0.
  - If slot != 0 at that edge, frame_abort<=1 for one cycle; else 0.
- en falling on the same cycle as a slot 2 word: en wins. The frame is discarded, frame_abort pulses, out_valid stays 0.
- busy = (slot != 0), registered state, no combinational path from inputs.
- port_in is don't-care when in_valid=0. No X propagation into outputs.
- Reset asserted mid-frame: immediate clear, no abort pulse.

Optional Feature:
Macro C6IBM_DESHIFT_FRAME_CNT_EN.
- Defined: adds output frame_cnt [15:0].
  - Increments on every out_valid pulse and wraps 0xFFFF -> 0.
  - Clears on reset and while en=0.
  - Adds output abort_cnt [7:0], which saturates at 0xFF.
- Undefined: neither port nor its counters exist. Core behaviour is identical.

Decomposition:
- Shared package c6ibm_pkg:
  - DATA_W and NUM_PORTS defaults.
  - Slot encoding constants SLOT_A=2'd0, SLOT_B=2'd1, SLOT_C=2'd2.
  - Frame-word typedef, DATA_W bits.
  - The serializer uses the same constants, so slot order stays consistent across both ends.
- One sub-module, c6ibm_slot_counter: the modulo-NUM_PORTS counter with advance and flush inputs and a wrap output. Everything else stays in the top module.

Test Plan:
- Reset then en=1, in_valid=1 with words 0x11111111, 0x22222222, 0x33333333 -> out_valid=1 on the 4th edge; A/B/C = 0x11111111/0x22222222/0x33333333; busy high for 2 cycles.
- Stall: same words with in_valid=0 for 2 cycles between word 1 and word 2 -> out_valid is 2 cycles later than in test 1; values unchanged; no abort.
- Back-to-back: 9 consecutive words 1..9 -> out_valid pulses 3 times, 3 cycles apart; frames (1,2,3), (4,5,6), (7,8,9).
- Abort: 2 words 0xAAAA0000 and 0xBBBB0000, then en=0 -> frame_abort=1 for exactly 1 cycle; out_port*=0; slot=0. Next frame 0xC/0xD/0xE is assembled correctly.
- Collision: en drops in the cycle the 3rd word arrives -> out_valid stays 0; frame_abort=1; with FRAME_CNT_EN, frame_cnt unchanged and abort_cnt +1.
- Loopback: serializer drives port_in with A=0xDEADBEEF, B=0x01234567, C=0xCAFEF00D -> deshifter outputs match; with FRAME_CNT_EN, frame_cnt increments by 1 per frame across 70000 frames and wraps.

Source files
------------

// File: rtl/c6ibm_pkg.sv
// ==== c6ibm_pkg : shared constants and types for the RAM port serializer/deshifter pair ====
// ==== rev 1.0 ===============================================================================
`default_nettype none

package c6ibm_pkg;

   localparam int DEF_DATA_W    = 32;
   localparam int DEF_NUM_PORTS = 3;
   localparam int DEF_CNT_W     = 2;

   // Slot order must match the serializer so word 0 lands on port A at both ends.
   localparam logic [1:0] SLOT_A = 2'd0;
   localparam logic [1:0] SLOT_B = 2'd1;
   localparam logic [1:0] SLOT_C = 2'd2;

   typedef logic [DEF_DATA_W-1:0] frame_word_t;

   typedef enum logic [0:0] {
      ST_IDLE    = 1'b0,
      ST_COLLECT = 1'b1
   } bus_state_e;

endpackage : c6ibm_pkg

`default_nettype wire

// File: rtl/c6ibm_port_deshifter_if.sv
// ==== c6ibm_port_deshifter_if : serial-in / parallel-out bus of the deshifter (opt: C6IBM_DESHIFT_FRAME_CNT_EN) ====
// ==== rev 1.0 ======================================================================================================
`default_nettype none

interface c6ibm_port_deshifter_if #(
   parameter int DATA_W = c6ibm_pkg::DEF_DATA_W
);
   logic              en;
   logic [DATA_W-1:0] port_in;
   logic              in_valid;
   logic [DATA_W-1:0] out_portA;
   logic [DATA_W-1:0] out_portB;
   logic [DATA_W-1:0] out_portC;
   logic              out_valid;
   logic              frame_abort;
   logic              busy;
`ifdef C6IBM_DESHIFT_FRAME_CNT_EN
   logic [15:0]       frame_cnt;
   logic [7:0]        abort_cnt;
`endif

   modport master (
      output en, port_in, in_valid,
      input  out_portA, out_portB, out_portC, out_valid, frame_abort, busy
`ifdef C6IBM_DESHIFT_FRAME_CNT_EN
      , input frame_cnt, abort_cnt
`endif
   );

   modport slave (
      input  en, port_in, in_valid,
      output out_portA, out_portB, out_portC, out_valid, frame_abort, busy
`ifdef C6IBM_DESHIFT_FRAME_CNT_EN
      , output frame_cnt, abort_cnt
`endif
   );

endinterface : c6ibm_port_deshifter_if

`default_nettype wire

// File: rtl/c6ibm_port_deshifter_slot_counter.sv
// ==== c6ibm_slot_counter : modulo-NUM_PORTS slot counter with advance/flush and wrap strobe ====
// ==== rev 1.0 ================================================================================
`default_nettype none

module c6ibm_slot_counter #(
   parameter int NUM_PORTS = c6ibm_pkg::DEF_NUM_PORTS,
   parameter int CNT_W     = c6ibm_pkg::DEF_CNT_W
) (
   input  wire logic             clk,
   input  wire logic             rst_n,
   input  wire logic             i_advance,
   input  wire logic             i_flush,
   output logic [CNT_W-1:0]      o_slot,
   output logic                  o_wrap
);

   logic [CNT_W-1:0] r_slot;
   logic             w_last;

   assign w_last = (r_slot == CNT_W'(NUM_PORTS - 1));
   assign o_wrap = i_advance & ~i_flush & w_last;
   assign o_slot = r_slot;

   // Flush has priority over advance so a disabled block never completes a frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_slot <= '0;
      end else if (i_flush) begin
         r_slot <= '0;
      end else if (i_advance) begin
         r_slot <= w_last ? '0 : r_slot + 1'b1;
      end
   end

endmodule : c6ibm_slot_counter

`default_nettype wire

// File: rtl/c6ibm_port_deshifter.sv
// ==== c6ibm_port_deshifter : rebuilds 3 serial RAM words into parallel ports A/B/C ====
// ==== optional macro C6IBM_DESHIFT_FRAME_CNT_EN adds frame/abort counters ; rev 1.0 ===
`default_nettype none

module c6ibm_port_deshifter
   import c6ibm_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int NUM_PORTS = DEF_NUM_PORTS,
   parameter int CNT_W     = DEF_CNT_W
) (
   input  wire logic             ram_clk,
   input  wire logic             rstn,
   c6ibm_port_deshifter_if.slave bus
);

   if (NUM_PORTS != 3) begin : g_bad_num_ports
      $error("c6ibm_port_deshifter: NUM_PORTS must be 3");
   end
   if ((2 ** CNT_W) < NUM_PORTS) begin : g_bad_cnt_w
      $error("c6ibm_port_deshifter: CNT_W too narrow for NUM_PORTS");
   end

   logic [CNT_W-1:0]  w_slot;
   logic              w_wrap;
   logic              w_acc;
   logic              w_emit;
   logic              w_abort;
   bus_state_e        r_state;
   bus_state_e        w_state_next;

   logic [DATA_W-1:0] r_stage_a;
   logic [DATA_W-1:0] r_stage_b;
   logic [DATA_W-1:0] r_out_a;
   logic [DATA_W-1:0] r_out_b;
   logic [DATA_W-1:0] r_out_c;
   logic              r_out_valid;
   logic              r_frame_abort;

   assign w_acc   = bus.en & bus.in_valid;
   assign w_emit  = w_wrap;
   assign w_abort = ~bus.en & (w_slot != '0);

   c6ibm_slot_counter #(
      .NUM_PORTS (NUM_PORTS),
      .CNT_W     (CNT_W)
   ) u_slot_counter (
      .clk       (ram_clk),
      .rst_n     (rstn),
      .i_advance (w_acc),
      .i_flush   (~bus.en),
      .o_slot    (w_slot),
      .o_wrap    (w_wrap)
   );

   always_ff @(posedge ram_clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      if (!bus.en) begin
         w_state_next = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE:    if (w_acc)  w_state_next = ST_COLLECT;
            ST_COLLECT: if (w_wrap) w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
         endcase
      end
   end

   // Disable clears the whole datapath; otherwise outputs only move on a completed frame.
   always_ff @(posedge ram_clk or negedge rstn) begin
      if (!rstn) begin
         r_stage_a     <= '0;
         r_stage_b     <= '0;
         r_out_a       <= '0;
         r_out_b       <= '0;
         r_out_c       <= '0;
         r_out_valid   <= 1'b0;
         r_frame_abort <= 1'b0;
      end else if (!bus.en) begin
         r_stage_a     <= '0;
         r_stage_b     <= '0;
         r_out_a       <= '0;
         r_out_b       <= '0;
         r_out_c       <= '0;
         r_out_valid   <= 1'b0;
         r_frame_abort <= w_abort;
      end else begin
         r_out_valid   <= w_emit;
         r_frame_abort <= 1'b0;
         if (w_acc) begin
            if (w_slot == CNT_W'(SLOT_A)) begin
               r_stage_a <= bus.port_in;
            end else if (w_slot == CNT_W'(SLOT_B)) begin
               r_stage_b <= bus.port_in;
            end
         end
         if (w_emit) begin
            r_out_a <= r_stage_a;
            r_out_b <= r_stage_b;
            r_out_c <= bus.port_in;
         end
      end
   end

   assign bus.out_portA   = r_out_a;
   assign bus.out_portB   = r_out_b;
   assign bus.out_portC   = r_out_c;
   assign bus.out_valid   = r_out_valid;
   assign bus.frame_abort = r_frame_abort;
   assign bus.busy        = (r_state == ST_COLLECT);

`ifdef C6IBM_DESHIFT_FRAME_CNT_EN
   logic [15:0] r_frame_cnt;
   logic [7:0]  r_abort_cnt;

   // Counters track the same edges that raise out_valid / frame_abort.
   always_ff @(posedge ram_clk or negedge rstn) begin
      if (!rstn) begin
         r_frame_cnt <= '0;
         r_abort_cnt <= '0;
      end else begin
         if (!bus.en) begin
            r_frame_cnt <= '0;
         end else if (w_emit) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
         end
         if (w_abort && (r_abort_cnt != 8'hFF)) begin
            r_abort_cnt <= r_abort_cnt + 8'd1;
         end
      end
   end

   assign bus.frame_cnt = r_frame_cnt;
   assign bus.abort_cnt = r_abort_cnt;
`endif

endmodule : c6ibm_port_deshifter

`default_nettype wire

// File: tb/tb_c6ibm_port_deshifter.sv
// ==== tb_c6ibm_port_deshifter : directed + random checks against a queue-based frame model ====
// ==== rev 1.0 ================================================================================
`default_nettype none

module tb_c6ibm_port_deshifter;
   import c6ibm_pkg::*;

   logic ram_clk = 1'b0;
   logic rstn;
   int   total = 0;
   int   bad   = 0;
   string phase = "init";

   always #5 ram_clk = ~ram_clk;

   c6ibm_port_deshifter_if #(.DATA_W(32)) bus ();

   c6ibm_port_deshifter #(
      .DATA_W    (32),
      .NUM_PORTS (3),
      .CNT_W     (2)
   ) dut (
      .ram_clk (ram_clk),
      .rstn    (rstn),
      .bus     (bus)
   );

   // Reference model: words accumulate in a queue; a full queue of three is a frame.
   frame_word_t q[$];
   frame_word_t m_a, m_b, m_c;
   logic        m_valid, m_abort;
`ifdef C6IBM_DESHIFT_FRAME_CNT_EN
   int          m_fcnt, m_acnt;
`endif

   task automatic model_reset();
      q.delete();
      m_a = '0; m_b = '0; m_c = '0;
      m_valid = 1'b0; m_abort = 1'b0;
`ifdef C6IBM_DESHIFT_FRAME_CNT_EN
      m_fcnt = 0; m_acnt = 0;
`endif
   endtask

   task automatic model_edge(input logic e, input logic v, input frame_word_t d);
      m_valid = 1'b0;
      m_abort = 1'b0;
      if (!e) begin
         m_abort = (q.size() != 0);
         q.delete();
         m_a = '0; m_b = '0; m_c = '0;
`ifdef C6IBM_DESHIFT_FRAME_CNT_EN
         m_fcnt = 0;
         if (m_abort && m_acnt < 255) m_acnt++;
`endif
      end else if (v) begin
         q.push_back(d);
         if (q.size() == 3) begin
            m_a = q[0]; m_b = q[1]; m_c = q[2];
            m_valid = 1'b1;
            q.delete();
`ifdef C6IBM_DESHIFT_FRAME_CNT_EN
            m_fcnt = (m_fcnt + 1) % 65536;
`endif
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s/%s: observed=%h expected=%h", phase, tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("portA", bus.out_portA, m_a);
      chk("portB", bus.out_portB, m_b);
      chk("portC", bus.out_portC, m_c);
      chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
      chk("frame_abort", 32'(bus.frame_abort), 32'(m_abort));
      chk("busy", 32'(bus.busy), 32'(q.size() != 0));
`ifdef C6IBM_DESHIFT_FRAME_CNT_EN
      chk("frame_cnt", 32'(bus.frame_cnt), 32'(m_fcnt));
      chk("abort_cnt", 32'(bus.abort_cnt), 32'(m_acnt));
`endif
   endtask

   // Inputs change on the falling edge; outputs are checked 1 ns after the rising edge.
   task automatic step(input logic e, input logic v, input frame_word_t d);
      bus.en       = e;
      bus.in_valid = v;
      bus.port_in  = d;
      @(posedge ram_clk);
      model_edge(e, v, d);
      #1;
      check_all();
      @(negedge ram_clk);
   endtask

   initial begin
      rstn         = 1'b0;
      bus.en       = 1'b0;
      bus.in_valid = 1'b0;
      bus.port_in  = '0;
      model_reset();
      repeat (2) @(negedge ram_clk);
      phase = "reset";
      check_all();
      rstn = 1'b1;

      phase = "basic";
      step(1, 1, 32'h11111111);
      step(1, 1, 32'h22222222);
      step(1, 1, 32'h33333333);
      chk("basic_valid_const", 32'(bus.out_valid), 32'd1);
      chk("basic_C_const", bus.out_portC, 32'h33333333);
      step(1, 0, $urandom);
      chk("hold_A_const", bus.out_portA, 32'h11111111);

      phase = "stall";
      step(1, 1, 32'h11111111);
      step(1, 0, $urandom);
      step(1, 0, $urandom);
      step(1, 1, 32'h22222222);
      step(1, 1, 32'h33333333);
      step(1, 0, $urandom);

      phase = "b2b";
      for (int i = 1; i <= 9; i++) step(1, 1, 32'(i));
      step(1, 0, $urandom);

      phase = "abort";
      step(1, 1, 32'hAAAA0000);
      step(1, 1, 32'hBBBB0000);
      step(0, 1, $urandom);
      chk("abort_const", 32'(bus.frame_abort), 32'd1);
      step(1, 0, $urandom);
      step(1, 1, 32'h0000000C);
      step(1, 1, 32'h0000000D);
      step(1, 1, 32'h0000000E);

      phase = "collision";
      step(1, 1, 32'h01010101);
      step(1, 1, 32'h02020202);
      step(0, 1, 32'h03030303);
      step(0, 0, $urandom);
      step(1, 0, $urandom);

      phase = "loopback";
      for (int f = 0; f < 4; f++) begin
         step(1, 1, 32'hDEADBEEF);
         step(1, 1, 32'h01234567);
         step(1, 1, 32'hCAFEF00D);
      end

      phase = "midreset";
      step(1, 1, 32'h55555555);
      step(1, 1, 32'h66666666);
      rstn = 1'b0;
      #1;
      model_reset();
      check_all();
      @(negedge ram_clk);
      check_all();
      rstn = 1'b1;
      step(1, 1, 32'h77777777);
      step(1, 1, 32'h88888888);
      step(1, 1, 32'h99999999);

      phase = "random";
      for (int n = 0; n < 3000; n++) begin
         step(($urandom_range(0, 11) != 0), ($urandom_range(0, 3) != 0), $urandom);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule : tb_c6ibm_port_deshifter

`default_nettype wire
